k_mul_issue: RTL

- Streaming front-end for the Kyber (q = 3329) coefficient-wise multiply path.
- Takes operand pairs over a valid/ready handshake and registers their 24-bit product, which drives the downstream fixed-latency reducer.
- Tracks each product through the reducer pipeline and captures the reduced 12-bit results, with their indices, into an output FIFO.
- The reducer cannot stall, so input acceptance is credit-limited: in-flight plus buffered results never exceed the FIFO depth.

---
 rtl/k_mul_issue.sv | 112 +++++++++++
 1 files changed

// File: rtl/k_mul_issue.sv
// Issue stage for the Kyber coefficient-wise multiply path. It registers the
// operand products, tracks them through the fixed-latency reducer and buffers the results.
module k_mul_issue #(
  parameter int unsigned KQ         = 3329,
  parameter int unsigned REDU_LAT   = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      a_coef,
  input  logic [11:0]      b_coef,
  input  logic [IDX_W-1:0] in_idx,
  output logic [23:0]      prod_out,
  input  logic [11:0]      redu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             range_err,
  output logic             busy
);

  localparam int unsigned PipeD = REDU_LAT + 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned FlyW  = $clog2(PipeD + 1);
  localparam logic [11:0] KqW   = 12'(KQ);

  logic [23:0]      prod_q;
  logic [PipeD-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [PipeD];
  logic [FlyW-1:0]  inflight_q, inflight_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic             range_err_q;
  logic [11:0]      data_mem [FIFO_DEPTH];
  logic [IDX_W-1:0] idx_mem [FIFO_DEPTH];

  logic accept, fifo_wr, fifo_pop, credit_ok;

  always_comb begin
    // Credits come from registered state only, so a pop frees a slot one cycle later.
    credit_ok = (32'(cnt_q) + 32'(inflight_q)) < FIFO_DEPTH;
    in_ready  = rst & credit_ok;
    accept    = in_valid & in_ready;
    fifo_wr   = vld_q[PipeD-1];
    out_valid = (cnt_q != '0);
    fifo_pop  = out_valid & out_ready;

    inflight_d = inflight_q;
    if (accept && !fifo_wr) begin
      inflight_d = inflight_q + FlyW'(1);
    end else if (!accept && fifo_wr) begin
      inflight_d = inflight_q - FlyW'(1);
    end

    cnt_d = cnt_q;
    if (fifo_wr && !fifo_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!fifo_wr && fifo_pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q      <= '0;
      vld_q       <= '0;
      for (int i = 0; i < int'(PipeD); i++) idx_q[i] <= '0;
      inflight_q  <= '0;
      cnt_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      range_err_q <= 1'b0;
    end else begin
      if (accept) begin
        prod_q <= {12'd0, a_coef} * {12'd0, b_coef};
        if (a_coef >= KqW || b_coef >= KqW) range_err_q <= 1'b1;
      end
      // The tracking pipe mirrors the reducer and shifts every cycle.
      vld_q    <= {vld_q[PipeD-2:0], accept};
      idx_q[0] <= in_idx;
      for (int i = 1; i < int'(PipeD); i++) idx_q[i] <= idx_q[i-1];
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      if (fifo_wr)  wptr_q <= wptr_q + PtrW'(1);
      if (fifo_pop) rptr_q <= rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      data_mem[wptr_q] <= redu_result;
      idx_mem[wptr_q]  <= idx_q[PipeD-1];
    end
  end

  always_comb begin
    prod_out  = prod_q;
    out_data  = data_mem[rptr_q];
    out_idx   = idx_mem[rptr_q];
    range_err = range_err_q;
    busy      = (inflight_q != '0) || (cnt_q != '0);
  end

  fifo_no_overflow_a: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_wr && cnt_q == CntW'(FIFO_DEPTH)));

endmodule
